// File: rtl/cdc_pkg.sv
// Shared definitions for the CDC FIFO design: filter FSM encoding and
// lower bounds on synchroniser depth and settle-filter length.
package cdc_pkg;

   typedef enum logic {
      ST_IDLE,
      ST_SETTLE
   } filt_state_t;

   localparam int MIN_STAGES        = 2;
   localparam int MIN_FILTER_CYCLES = 1;

endpackage

// File: rtl/sync_chain.sv
// Multi-bit register-chain synchroniser into the b_clk domain.
// Every bit sees the same depth; no cross-bit coherence is attempted here.
module sync_chain #(
   parameter int WIDTH  = 4,
   parameter int STAGES = 2
) (
   input  logic             b_clk,
   input  logic             b_rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stage [STAGES];

   always_ff @(posedge b_clk) begin
      if (b_rst) begin
         for (int i = 0; i < STAGES; i++) begin
            stage[i] <= '0;
         end
      end else begin
         stage[0] <= d;
         for (int i = 1; i < STAGES; i++) begin
            stage[i] <= stage[i-1];
         end
      end
   end

   assign q = stage[STAGES-1];

endmodule

// File: rtl/sync_filter_bus.sv
// Synchronised, glitch-filtered status bus with change pulse.
// Per-bit rise/fall pulses are built only when SYNC_FILTER_EDGE_EN is defined.
module sync_filter_bus #(
   parameter int WIDTH         = 4,
   parameter int STAGES        = 2,
   parameter int FILTER_CYCLES = 4
) (
   input  logic             b_clk,
   input  logic             b_rst,
   input  logic [WIDTH-1:0] async_data,
   output logic [WIDTH-1:0] sync_data,
   output logic             data_changed,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall
);
   import cdc_pkg::*;

   localparam int CW = $clog2(FILTER_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic [WIDTH-1:0] s;
   logic [WIDTH-1:0] cand, cand_n;
   logic [WIDTH-1:0] data_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic             chg_n;
   filt_state_t      state, state_n;

   sync_chain #(
      .WIDTH  (WIDTH),
      .STAGES (STAGES)
   ) u_chain (
      .b_clk (b_clk),
      .b_rst (b_rst),
      .d     (async_data),
      .q     (s)
   );

   always_ff @(posedge b_clk) begin
      if (b_rst) begin
         state        <= ST_IDLE;
         cand         <= '0;
         cnt          <= '0;
         sync_data    <= '0;
         data_changed <= 1'b0;
      end else begin
         state        <= state_n;
         cand         <= cand_n;
         cnt          <= cnt_n;
         sync_data    <= data_n;
         data_changed <= chg_n;
      end
   end

   always_comb begin
      state_n = state;
      cand_n  = cand;
      cnt_n   = cnt;
      data_n  = sync_data;
      chg_n   = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (s != sync_data) begin
               if (FILTER_CYCLES == 1) begin
                  data_n = s;
                  chg_n  = 1'b1;
               end else begin
                  cand_n  = s;
                  cnt_n   = CNT_ONE;
                  state_n = ST_SETTLE;
               end
            end
         end
         ST_SETTLE: begin
            if (s == sync_data) begin
               cnt_n   = '0;
               state_n = ST_IDLE;
            end else if (s != cand) begin
               // a different value restarts the settle count
               cand_n = s;
               cnt_n  = CNT_ONE;
            end else if (cnt == CNT_LAST) begin
               data_n  = cand;
               chg_n   = 1'b1;
               cnt_n   = '0;
               state_n = ST_IDLE;
            end else begin
               cnt_n = cnt + CNT_ONE;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

`ifdef SYNC_FILTER_EDGE_EN
   always_ff @(posedge b_clk) begin
      if (b_rst) begin
         rise <= '0;
         fall <= '0;
      end else if (chg_n) begin
         rise <= data_n & ~sync_data;
         fall <= ~data_n & sync_data;
      end else begin
         rise <= '0;
         fall <= '0;
      end
   end
`else
   assign rise = '0;
   assign fall = '0;
`endif

endmodule
